// File: rtl/shift_pipe_stage_pkg.sv
// Shared constants and types for the registered shifter stage.
package shift_pipe_stage_pkg;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] SH_LL0 = 2'b00;
  localparam logic [1:0] SH_LL  = 2'b01;
  localparam logic [1:0] SH_LR  = 2'b10;
  localparam logic [1:0] SH_AR  = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [SHAMT_W-1:0] b;
    logic [1:0]         c;
  } shift_req_t;
endpackage

// File: rtl/shifter_32.sv
// Combinational 32-bit shifter core: logical left, logical right, arithmetic right.
import shift_pipe_stage_pkg::*;

module shifter_32 (
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] b,
  input  logic [1:0]         c,
  output logic [DATA_W-1:0]  z
);
  always_comb begin
    z = a << b;
    case (c)
      SH_LL0, SH_LL: z = a << b;
      SH_LR:         z = a >> b;
      SH_AR:         z = $signed(a) >>> b;
      default:       z = a << b;
    endcase
  end
endmodule

// File: rtl/shift_pipe_stage.sv
// Two-stage valid/ready wrapper around shifter_32 (operand reg, result reg).
// SHIFT_PIPE_ROTATE_EN turns type 00 into rotate-left; otherwise 00 is a logical left.
import shift_pipe_stage_pkg::*;

module shift_pipe_stage #(
  parameter int DATA_W  = shift_pipe_stage_pkg::DATA_W,
  parameter int SHAMT_W = shift_pipe_stage_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [SHAMT_W-1:0] in_b,
  input  logic [1:0]         in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_z,
  output logic [1:0]         out_c,
  output logic               out_zero
);
  // vld_pipe[1] = stage 1 holds an op, vld_pipe[2] = result register holds one
  logic [2:1]        vld_pipe;
  shift_req_t        s1;
  logic [DATA_W-1:0] core_z;
  logic [DATA_W-1:0] res;
  logic              s2_adv, s1_adv, in_fire, out_fire;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = vld_pipe[1] && s2_adv;
  assign in_ready  = !vld_pipe[1] || s2_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld_pipe[2];
  assign out_fire  = vld_pipe[2] && out_ready;

  shifter_32 u_core (
    .a (s1.a),
    .b (s1.b),
    .c (s1.c),
    .z (core_z)
  );

`ifdef SHIFT_PIPE_ROTATE_EN
  logic [SHAMT_W:0]  rot_rsh;
  logic [DATA_W-1:0] rot_z;

  // A right shift by DATA_W yields zero, so b = 0 falls out as a pass-through.
  assign rot_rsh = (SHAMT_W+1)'(DATA_W) - {1'b0, s1.b};
  assign rot_z   = (s1.a << s1.b) | (s1.a >> rot_rsh);
  assign res     = (s1.c == SH_LL0) ? rot_z : core_z;
`else
  assign res     = core_z;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      out_z    <= '0;
      out_c    <= '0;
      out_zero <= 1'b0;
    end else begin
      if (in_fire) begin
        s1          <= '{a: in_a, b: in_b, c: in_c};
        vld_pipe[1] <= 1'b1;
      end else if (s1_adv) begin
        vld_pipe[1] <= 1'b0;
      end

      if (s1_adv) begin
        out_z       <= res;
        out_c       <= s1.c;
        out_zero    <= (res == '0);
        vld_pipe[2] <= 1'b1;
      end else if (out_fire) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end
endmodule
